// File: rtl/led_bank_arbiter_if.sv
// led_bank_arbiter_if
// Bundle of signals between the puzzle modules and the LED bank arbiter.
//   req    : one level-held request per requester
//   pat_in : requester i pattern at bits [i*WIDTH +: WIDTH]
//   alarm  : global override, blanks the bank and revokes any grant
//   gnt    : one-hot current owner (zero when nobody owns the bank)
//   led    : registered LED drive
//   busy   : arbiter is not idle
// Modports: master = requester side, slave = arbiter side.
interface led_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 25
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] pat_in;
  logic                  alarm;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      led;
  logic                  busy;

  modport master (output req, pat_in, alarm, input gnt, led, busy);
  modport slave  (input req, pat_in, alarm, output gnt, led, busy);
endinterface

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter
// Shares one LED bank between NREQ requesters with round-robin arbitration,
// a minimum hold time per owner, a one-cycle blank gap between owners and a
// global alarm override that forces all LEDs off.
// Ports:
//   clk_i   : clock, all state on posedge
//   reset_i : asynchronous active-high reset
//   bus     : led_bank_arbiter_if.slave (req, pat_in, alarm in; gnt, led, busy out)
// Optional feature: define BLINK_EN to blink the owner pattern during GRANT
// with half-period BLINK_CYC (the parameter exists only in that build).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no owner; led = IDLE_PAT, or 0 while alarm is high
// S_GRANT | gnt one-hot, led follows owner pattern one cycle late
// S_GAP   | single blank cycle between owners, led = IDLE_PAT
module led_bank_arbiter #(
  parameter int               NREQ     = 4,
  parameter int               WIDTH    = 25,
  parameter int               HOLD_CYC = 8,
  parameter logic [WIDTH-1:0] IDLE_PAT = '1
`ifdef BLINK_EN
  , parameter int             BLINK_CYC = 4
`endif
) (
  input  logic             clk_i,
  input  logic             reset_i,
  led_bank_arbiter_if.slave bus
);
  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(HOLD_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [LW-1:0]    last_q, last_d;
  logic [LW-1:0]    win;
  logic             any_req;
  logic             other_req;
  logic [WIDTH-1:0] pats [NREQ];

`ifdef BLINK_EN
  localparam int BW = $clog2(BLINK_CYC + 1);
  logic          phase_q, phase_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
`endif

  for (genvar i = 0; i < NREQ; i++) begin : g_pat
    assign pats[i] = bus.pat_in[i*WIDTH +: WIDTH];
  end

  assign any_req   = |bus.req;
  assign other_req = |(bus.req & ~gnt_q);

  // Round-robin pick: lowest requester above last, else lowest at/below last.
  // The upper pass runs second so it overrides the wrap-around pass.
  always_comb begin
    win = last_q;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i] && (LW'(i) <= last_q)) win = LW'(i);
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i] && (LW'(i) > last_q)) win = LW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    led_d   = led_q;
    hold_d  = hold_q;
    last_d  = last_q;
`ifdef BLINK_EN
    phase_d = phase_q;
    bcnt_d  = bcnt_q;
`endif
    case (state_q)
      S_GRANT: begin
        if (bus.alarm) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          led_d   = '0;
          hold_d  = '0;
        end else if (!bus.req[last_q] ||
                     ((hold_q == HW'(HOLD_CYC)) && other_req)) begin
          state_d = S_GAP;
          gnt_d   = '0;
          led_d   = IDLE_PAT;
          hold_d  = '0;
        end else begin
          if (hold_q != HW'(HOLD_CYC)) hold_d = hold_q + HW'(1);
`ifdef BLINK_EN
          if (bcnt_q == BW'(BLINK_CYC)) begin
            phase_d = ~phase_q;
            bcnt_d  = BW'(1);
          end else begin
            bcnt_d  = bcnt_q + BW'(1);
          end
          led_d = pats[last_q] & {WIDTH{phase_d}};
`else
          led_d = pats[last_q];
`endif
        end
      end
      default: begin
        // IDLE and GAP arbitrate identically; GAP always leaves after one cycle.
        gnt_d  = '0;
        hold_d = '0;
        if (bus.alarm) begin
          state_d = S_IDLE;
          led_d   = '0;
        end else if (any_req) begin
          state_d = S_GRANT;
          gnt_d   = NREQ'(1) << win;
          led_d   = pats[win];
          last_d  = win;
          hold_d  = HW'(1);
`ifdef BLINK_EN
          phase_d = 1'b1;
          bcnt_d  = BW'(1);
`endif
        end else begin
          state_d = S_IDLE;
          led_d   = IDLE_PAT;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      led_q   <= IDLE_PAT;
      hold_q  <= '0;
      last_q  <= LW'(NREQ - 1);
`ifdef BLINK_EN
      phase_q <= 1'b1;
      bcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      led_q   <= led_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
`ifdef BLINK_EN
      phase_q <= phase_d;
      bcnt_q  <= bcnt_d;
`endif
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.led  = led_q;
  assign bus.busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb_led_bank_arbiter
// Directed bench for led_bank_arbiter (NREQ=4, WIDTH=25, HOLD_CYC=8).
// Expected outputs are queued when stimulus is applied and popped after the
// clock edge that should produce them.
module tb_led_bank_arbiter;
  localparam logic [24:0] IP = 25'h1FFFFFF;
  localparam logic [24:0] P0 = 25'h0000ABC;
  localparam logic [24:0] P1 = 25'h0111111;
  localparam logic [24:0] P2 = 25'h0222222;
  localparam logic [24:0] P3 = 25'h1234567;

  typedef struct {
    logic [3:0]  g;
    logic [24:0] l;
    logic        b;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  led_bank_arbiter_if #(.NREQ(4), .WIDTH(25)) bus ();

  led_bank_arbiter #(
    .NREQ(4), .WIDTH(25), .HOLD_CYC(8), .IDLE_PAT(25'h1FFFFFF)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  // Owner pattern on the k-th cycle of a grant (k starts at 1).
  function automatic logic [24:0] exp_own(input logic [24:0] p, input int k);
    logic on;
`ifdef BLINK_EN
    on = (((k - 1) / 4) % 2) == 0;
`else
    on = (k >= 1);
`endif
    return on ? p : 25'h0;
  endfunction

  task automatic push(input string tag, input logic [3:0] eg, input logic [24:0] el,
                      input logic eb);
    exp_t e;
    e.g = eg; e.l = el; e.b = eb; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    total++;
    assert ({bus.gnt, bus.led, bus.busy} === {e.g, e.l, e.b})
    else begin
      bad++;
      $error("FAIL %s: got gnt=%b led=%h busy=%b, want gnt=%b led=%h busy=%b",
             e.tag, bus.gnt, bus.led, bus.busy, e.g, e.l, e.b);
    end
  endtask

  task automatic check_now(input string tag, input logic [3:0] eg, input logic [24:0] el,
                           input logic eb);
    push(tag, eg, el, eb);
    check_out();
  endtask

  task automatic cyc(input string tag, input logic [3:0] eg, input logic [24:0] el,
                     input logic eb);
    push(tag, eg, el, eb);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    bus.req    = 4'b0000;
    bus.alarm  = 1'b0;
    bus.pat_in = {P3, P2, P1, P0};
    repeat (2) @(posedge clk);
    #1;
    check_now("rst_init", 4'b0000, IP, 1'b0);
    rst = 1'b0;
    cyc("idle_after_rst", 4'b0000, IP, 1'b0);

    // single owner, pattern tracking, indefinite hold, drop -> GAP -> IDLE
    bus.req = 4'b0001;
    cyc("t2_grant", 4'b0001, exp_own(P0, 1), 1'b1);
    bus.pat_in = {P3, P2, P1, 25'h0000DEF};
    cyc("t2_track", 4'b0001, exp_own(25'h0000DEF, 2), 1'b1);
    for (int k = 3; k <= 12; k++) cyc("t2_hold", 4'b0001, exp_own(25'h0000DEF, k), 1'b1);
    bus.req = 4'b0000;
    cyc("t2_gap", 4'b0000, IP, 1'b1);
    cyc("t2_idle", 4'b0000, IP, 1'b0);
    bus.pat_in = {P3, P2, P1, P0};

    // async reset mid-GRANT (last=0, so requester 2 wins)
    bus.req = 4'b0100;
    cyc("t1_grant", 4'b0100, exp_own(P2, 1), 1'b1);
    #3 rst = 1'b1;
    #1 check_now("t1_async_rst", 4'b0000, IP, 1'b0);
    bus.req = 4'b0000;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc("t1_idle_a", 4'b0000, IP, 1'b0);
    cyc("t1_idle_b", 4'b0000, IP, 1'b0);

    // two competitors: 8-cycle turns with one GAP between
    bus.req = 4'b1010;
    for (int k = 1; k <= 8; k++) cyc("t3_own1", 4'b0010, exp_own(P1, k), 1'b1);
    cyc("t3_gap1", 4'b0000, IP, 1'b1);
    for (int k = 1; k <= 8; k++) cyc("t3_own3", 4'b1000, exp_own(P3, k), 1'b1);
    cyc("t3_gap2", 4'b0000, IP, 1'b1);
    cyc("t3_own1_again", 4'b0010, exp_own(P1, 1), 1'b1);
    bus.req = 4'b0000;
    cyc("t3_gap3", 4'b0000, IP, 1'b1);
    cyc("t3_idle", 4'b0000, IP, 1'b0);

    // late competitor: no early preemption (last=1, requester 1 wins)
    bus.req = 4'b0010;
    for (int k = 1; k <= 2; k++) cyc("t4_own1", 4'b0010, exp_own(P1, k), 1'b1);
    bus.req = 4'b1010;
    for (int k = 3; k <= 8; k++) cyc("t4_own1_held", 4'b0010, exp_own(P1, k), 1'b1);
    cyc("t4_gap", 4'b0000, IP, 1'b1);
    cyc("t4_own3", 4'b1000, exp_own(P3, 1), 1'b1);
    bus.req = 4'b0000;
    cyc("t4_gap2", 4'b0000, IP, 1'b1);
    cyc("t4_idle", 4'b0000, IP, 1'b0);

    // alarm during GRANT, then re-grant (last=3, requester 2 wins)
    bus.req = 4'b0100;
    for (int k = 1; k <= 2; k++) cyc("t5_own2", 4'b0100, exp_own(P2, k), 1'b1);
    bus.alarm = 1'b1;
    for (int k = 0; k < 3; k++) cyc("t5_alarm", 4'b0000, 25'h0, 1'b0);
    bus.alarm = 1'b0;
    cyc("t5_regrant", 4'b0100, exp_own(P2, 1), 1'b1);
    bus.req = 4'b0000;
    cyc("t5_gap", 4'b0000, IP, 1'b1);
    cyc("t5_idle", 4'b0000, IP, 1'b0);

    // alarm in IDLE blocks grants; release returns to IDLE_PAT
    bus.alarm = 1'b1;
    cyc("t7_alarm_idle", 4'b0000, 25'h0, 1'b0);
    bus.req = 4'b0001;
    cyc("t7_alarm_req", 4'b0000, 25'h0, 1'b0);
    cyc("t7_alarm_req2", 4'b0000, 25'h0, 1'b0);
    bus.req   = 4'b0000;
    bus.alarm = 1'b0;
    cyc("t7_release", 4'b0000, IP, 1'b0);

    // all request at once from IDLE (last=2): 3 first, then wrap to 0
    bus.req = 4'b1111;
    for (int k = 1; k <= 8; k++) cyc("t8_own3", 4'b1000, exp_own(P3, k), 1'b1);
    cyc("t8_gap", 4'b0000, IP, 1'b1);
    cyc("t8_own0", 4'b0001, exp_own(P0, 1), 1'b1);
    bus.req = 4'b0000;
    cyc("t8_gap2", 4'b0000, IP, 1'b1);
    cyc("t8_idle", 4'b0000, IP, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
